// File: rtl/modcounter_pkg.sv
// Shared constants and helpers for the modcounter timebase/event counter.
// Optional build macro: MODCOUNTER_SATURATE_EN (saturate instead of wrapping).
package modcounter_pkg;

   localparam int DEF_WIDTH    = 8;
   localparam int DEF_MODULUS  = 256;
   localparam int DEF_PRESCALE = 1;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   // Prescaler counter width; a single-cycle prescaler still keeps one bit.
   function automatic int presc_width(input int prescale);
      return (prescale <= 2) ? 1 : $clog2(prescale);
   endfunction

endpackage

// File: rtl/modcounter_if.sv
// Control/data bundle for modcounter; master drives controls, slave is the counter.
// Optional build macro affecting the counter: MODCOUNTER_SATURATE_EN.
interface modcounter_if #(
   parameter int WIDTH = 8
);
   logic             en_in;
   logic             up_in;
   logic             load_in;
   logic [WIDTH-1:0] load_data_in;
   logic [WIDTH-1:0] data_out;
   logic             tc_out;
   logic             wrap_out;

   modport master (
      output en_in, up_in, load_in, load_data_in,
      input  data_out, tc_out, wrap_out
   );

   modport slave (
      input  en_in, up_in, load_in, load_data_in,
      output data_out, tc_out, wrap_out
   );
endinterface

// File: rtl/modcounter_prescaler.sv
// Divides enabled cycles by PRESCALE into a single-cycle tick; holds while disabled.
// Unaffected by MODCOUNTER_SATURATE_EN.
module modcounter_prescaler
   import modcounter_pkg::*;
#(
   parameter int PRESCALE = DEF_PRESCALE
) (
   input  logic clk_in,
   input  logic rst_in,
   input  logic clr_in,
   input  logic en_in,
   output logic tick_out
);

   localparam int             CW   = presc_width(PRESCALE);
   localparam logic [CW-1:0]  LAST = CW'(PRESCALE - 1);

   logic [CW-1:0] cnt;

   // Tick is combinational so PRESCALE=1 steps on the same edge en_in is sampled.
   assign tick_out = en_in && (cnt == LAST);

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         cnt <= '0;
      end else if (clr_in) begin
         cnt <= '0;
      end else if (en_in) begin
         cnt <= tick_out ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/modcounter.sv
// Parametrised up/down modulo counter with prescaler, parallel load and wrap pulse.
// Build macro MODCOUNTER_SATURATE_EN: hold at the terminal value and never pulse wrap_out.
module modcounter
   import modcounter_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int MODULUS  = DEF_MODULUS,
   parameter int PRESCALE = DEF_PRESCALE
) (
   input  logic         clk_in,
   input  logic         rst_in,
   modcounter_if.slave  bus
);

   // MODULUS may be 2**WIDTH, so the limit is truncated to WIDTH bits (all-ones).
   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);

   logic             tick;
   logic             tc;
   logic [WIDTH-1:0] count;
   logic             wrap_q;
   logic [WIDTH-1:0] step_val;
   logic [WIDTH-1:0] load_val;
   logic             wrap_next;

   modcounter_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .clr_in   (bus.load_in),
      .en_in    (bus.en_in),
      .tick_out (tick)
   );

   assign tc = (bus.up_in == DIR_UP) ? (count == MAX_VAL) : (count == '0);

   always_comb begin
      step_val  = count;
      wrap_next = 1'b0;
      load_val  = ({1'b0, bus.load_data_in} >= MOD_EXT) ? MAX_VAL : bus.load_data_in;
`ifdef MODCOUNTER_SATURATE_EN
      if (!tc) begin
         step_val = (bus.up_in == DIR_UP) ? count + 1'b1 : count - 1'b1;
      end
`else
      if (bus.up_in == DIR_UP) begin
         step_val = tc ? '0 : count + 1'b1;
      end else begin
         step_val = tc ? MAX_VAL : count - 1'b1;
      end
      wrap_next = tick & tc;
`endif
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         count  <= '0;
         wrap_q <= 1'b0;
      end else if (bus.load_in) begin
         count  <= load_val;
         wrap_q <= 1'b0;
      end else begin
         if (tick) begin
            count <= step_val;
         end
         wrap_q <= wrap_next;
      end
   end

   assign bus.data_out = count;
   assign bus.tc_out   = tc;
   assign bus.wrap_out = wrap_q;

endmodule
